// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC sequencing stage.
package mac_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } mac_seq_state_e;

   // Per-byte activation offsets applied by the mac unit
   localparam int INPUT_OFFSET_DEFAULT   = 128;
   localparam int INPUT_OFFSET_LAYER_ONE = -83;

endpackage

// File: rtl/mac.sv
// Combinational 4-lane int8 multiply-accumulate: out = curr_acc + sum((in+offset)*filt).
module mac (
   input  logic [31:0] input_vals,
   input  logic [31:0] filter_vals,
   input  logic [31:0] curr_acc,
   input  logic        layer_one_en,
   input  logic        simd_en,
   output logic [31:0] out
);

   localparam int unsigned LANES = 4;
   localparam logic signed [8:0] OFFSET_DEFAULT   = 9'sd128;
   localparam logic signed [8:0] OFFSET_LAYER_ONE = -9'sd83;

   logic signed [8:0]  offset_c;
   logic signed [8:0]  act_c   [LANES];
   logic signed [15:0] prod_c  [LANES];
   logic        [31:0] sum_c;

   assign offset_c = layer_one_en ? OFFSET_LAYER_ONE : OFFSET_DEFAULT;

   // Without SIMD only lane 0 contributes
   always_comb begin
      sum_c = curr_acc;
      for (int i = 0; i < int'(LANES); i++) begin
         act_c[i]  = 9'($signed(input_vals[8*i +: 8])) + offset_c;
         prod_c[i] = 16'(act_c[i] * $signed(filter_vals[8*i +: 8]));
         if ((i == 0) || simd_en) begin
            sum_c = sum_c + 32'(prod_c[i]);
         end
      end
   end

   assign out = sum_c;

endmodule

// File: rtl/mac_sequencer.sv
// Streams int8 word pairs through mac, owns the accumulator, and hands the
// finished sum downstream on a valid/ready port after a programmed depth.
module mac_sequencer
   import mac_seq_pkg::*;
#(
   parameter int unsigned ACC_W   = 32,
   parameter int unsigned DEPTH_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cfg_start,
   input  logic [DEPTH_W-1:0] cfg_depth,
   input  logic [ACC_W-1:0]   cfg_bias,
   input  logic               cfg_layer_one_en,
   input  logic               cfg_simd_en,
   output logic               busy,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_input_vals,
   input  logic [31:0]        in_filter_vals,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [ACC_W-1:0]   out_acc
);

   mac_seq_state_e     state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [DEPTH_W-1:0] count_q, count_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               layer_one_q, layer_one_d;
   logic               simd_q, simd_d;
   logic               busy_q, in_ready_q, out_valid_q;
   logic               start_c;
   logic [ACC_W-1:0]   mac_out_c;

   mac u_mac (
      .input_vals   (in_input_vals),
      .filter_vals  (in_filter_vals),
      .curr_acc     (acc_q),
      .layer_one_en (layer_one_q),
      .simd_en      (simd_q),
      .out          (mac_out_c)
   );

   // Next-state: start is honoured in IDLE or on the DONE handshake cycle
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      count_d     = count_q;
      depth_d     = depth_q;
      layer_one_d = layer_one_q;
      simd_d      = simd_q;
      start_c     = 1'b0;
      case (state_q)
         IDLE: start_c = cfg_start;
         ACCUM: begin
            if (in_valid && in_ready_q) begin
               acc_d   = mac_out_c;
               count_d = count_q + DEPTH_W'(1);
               if (count_q == depth_q - DEPTH_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               start_c = cfg_start;
            end
         end
         default: state_d = IDLE;
      endcase
      if (start_c) begin
         depth_d     = cfg_depth;
         layer_one_d = cfg_layer_one_en;
         simd_d      = cfg_simd_en;
         acc_d       = cfg_bias;
         count_d     = '0;
         state_d     = (cfg_depth == '0) ? DONE : ACCUM;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         count_q     <= '0;
         depth_q     <= '0;
         layer_one_q <= 1'b0;
         simd_q      <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         depth_q     <= depth_d;
         layer_one_q <= layer_one_d;
         simd_q      <= simd_d;
         busy_q      <= (state_d != IDLE);
         in_ready_q  <= (state_d == ACCUM);
         out_valid_q <= (state_d == DONE);
      end
   end

   assign busy      = busy_q;
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_acc   = acc_q;

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Sequencing stage wrapped around the existing combinational `mac` unit.
- Accepts a valid/ready stream of packed int8 input/filter word pairs and owns the running accumulator register, which it feeds back as `mac.curr_acc`.
- Counts words up to a programmed depth, then presents the finished 32-bit accumulator downstream (to requantisation/output) on a valid/ready port.

Parameters:
- ACC_W, 32, accumulator and bias width; must equal the `mac` out width.
- DEPTH_W, 16, width of the word-count register and `cfg_depth`.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse that starts a dot product.
- cfg_depth  in  DEPTH_W  number of word pairs to consume; latched on accepted start.
- cfg_bias  in  ACC_W  initial accumulator value; latched on accepted start.
- cfg_layer_one_en  in  1  passed to `mac.layer_one_en`; latched on accepted start.
- cfg_simd_en  in  1  passed to `mac.simd_en`; latched on accepted start.
- busy  out  1  high whenever the state is not IDLE.
- in_valid  in  1  input word pair valid.
- in_ready  out  1  block can accept an input pair.
- in_input_vals  in  32  four packed int8 activations.
- in_filter_vals  in  32  four packed int8 weights.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_acc  out  ACC_W  final accumulator.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; acc, count, latched config all 0.
  - busy=0, in_ready=0, out_valid=0, out_acc=0.
  - Reset asserted mid-run discards the partial sum; no output is produced.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On cfg_start: latch config; acc<=cfg_bias; count<=0.
  - Next state is ACCUM, or DONE if cfg_depth==0.
- ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready: acc<=mac.out computed with curr_acc=acc and the latched enables; count<=count+1.
  - If count==depth-1 at that handshake, next state is DONE.
  - Cycles with in_valid=0 are stalls; nothing changes.
- DONE:
  - out_valid=1, out_acc=acc, in_ready=0.
  - out_acc holds stable while out_ready=0.
  - On out_ready: return to IDLE.
  - If cfg_start is high in the same cycle as the out handshake, it is accepted: go directly to ACCUM (or DONE if depth 0) with the new config. This gives a zero-bubble back-to-back start.
- cfg_start outside IDLE (and outside the DONE-handshake cycle) is ignored; no error flag.
- cfg_* changes during a run have no effect; only the latched copies drive `mac`.
- Latency:
  - Result valid the cycle after the final input handshake.
  - depth 0: result valid the cycle after start, with out_acc=bias.
  - Throughput is one word pair per cycle.
- Arithmetic:
  - The accumulator is two's complement ACC_W bits and wraps modulo 2^ACC_W, with no saturation (same as `mac`).
  - Per-byte offset: +128 normally, -83 when layer_one_en; signed int8 filter; 16-bit products.
  - simd_en=0 uses byte 0 only.
- out_acc is driven from the register, not from mac.out combinationally.

Decomposition:
- Package mac_seq_pkg: state enum (IDLE, ACCUM, DONE); constants INPUT_OFFSET_DEFAULT=128 and INPUT_OFFSET_LAYER_ONE=-83, shared for bench reference models.
- One sub-module instance: the existing `mac`, used unmodified. No new sub-modules.

Test Plan:
- SIMD, offset 128, bias=10, depth=3, each word in=0x00000000, filt=0x01010101 -> each word adds 4*128=512; out_acc=1546, out_valid exactly one cycle after the 3rd handshake.
- Non-SIMD, depth=2, bias=0, in=0xFFFFFF7F, filt=0xFFFFFF80 -> per word (127+128)*(-128)=-32640; out_acc=-65280 (0xFFFF0100).
- layer_one_en=1, SIMD, depth=4, in=0x53535353, filt=0x7F7F7F7F, bias=-5 -> all products 0; out_acc=-5.
- depth=0, bias=0x12345678 -> DONE one cycle after start, out_acc=0x12345678, in_ready never high.
- Wrap and backpressure, three steps:
  - Run: bias=0x7FFFFFFF, depth=1, SIMD, in=0, filt=0x01010101 -> out_acc=0x800001FF.
  - Hold: keep out_ready=0 for 5 cycles -> out_valid and out_acc stable throughout.
  - Restart: assert out_ready together with cfg_start -> next run begins with no IDLE cycle.
- Robustness, three steps:
  - Stall: in_valid toggles -> result matches the stall-free run.
  - Late start: cfg_start during ACCUM -> ignored.
  - Reset: reset_n=0 after 2 of 4 words -> outputs go to 0 immediately; the next run (bias=0, depth=1) gives a correct fresh result.
